// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 key-event decoder.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // Bytes that never form part of a key event (error, BAT, ACK, resend)
  localparam logic [7:0] PS2_NUL = 8'h00;
  localparam logic [7:0] PS2_ERR = 8'hFF;
  localparam logic [7:0] PS2_BAT = 8'hAA;
  localparam logic [7:0] PS2_ACK = 8'hFA;
  localparam logic [7:0] PS2_RSD = 8'hFE;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } dec_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_event_t;

  function automatic logic is_discard(input logic [7:0] c);
    return (c == PS2_NUL) || (c == PS2_ERR) || (c == PS2_BAT) ||
           (c == PS2_ACK) || (c == PS2_RSD);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Show-ahead synchronous FIFO of key events; head is always mem[rd_ptr].
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_push,
  input  key_event_t i_data,
  input  logic       i_pop,
  output key_event_t o_data,
  output logic       o_full,
  output logic       o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  key_event_t      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            w_do_push;
  logic            w_do_pop;

  // A pop frees a slot this cycle, so a push while full is accepted alongside it
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_data  = r_mem[r_rd_ptr];

  // Storage and pointer/occupancy update
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// Scan-code byte stream to key make/break events with typematic filtering.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       res,
  input  logic [7:0] code_in,
  input  logic       code_valid,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic       overflow,
  output logic [7:0] held_code,
  output logic       held_ext
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  dec_state_t  r_state;
  dec_state_t  w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic        r_ovf;
  logic [7:0]  r_held_code;
  logic        r_held_ext;
  logic        w_emit;
  logic        w_match;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  key_event_t  w_ev;
  key_event_t  w_head;

  // Prefix decoding and idle timeout
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_emit      = 1'b0;
    w_ev        = '0;
    if (code_valid) begin
      w_cnt_nxt = '0;
      if (!is_discard(code_in)) begin
        case (r_state)
          IDLE: begin
            if (code_in == PS2_EXT)      w_state_nxt = EXT;
            else if (code_in == PS2_BRK) w_state_nxt = BRK;
            else begin
              w_emit = 1'b1;
              w_ev   = '{ext: 1'b0, brk: 1'b0, code: code_in};
            end
          end
          EXT: begin
            if (code_in == PS2_BRK) w_state_nxt = EXT_BRK;
            else if (code_in != PS2_EXT) begin
              w_emit      = 1'b1;
              w_ev        = '{ext: 1'b1, brk: 1'b0, code: code_in};
              w_state_nxt = IDLE;
            end
          end
          default: begin
            if ((code_in != PS2_EXT) && (code_in != PS2_BRK)) begin
              w_emit      = 1'b1;
              w_ev        = '{ext: (r_state == EXT_BRK), brk: 1'b1, code: code_in};
              w_state_nxt = IDLE;
            end
          end
        endcase
      end
    end else if (r_state != IDLE) begin
      if (r_cnt == CW'(TIMEOUT - 1)) begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt = r_cnt + CW'(1);
      end
    end
  end

  // Typematic repeats of the held key are suppressed; breaks always pass
  assign w_match = ({w_ev.ext, w_ev.code} == {r_held_ext, r_held_code});
  assign w_push  = w_emit & (w_ev.brk | ~(w_match & (r_held_code != 8'h00)));
  assign w_pop   = ev_valid & ev_ready;

  // FSM, timeout counter, held key and sticky overflow
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_held_code <= 8'h00;
      r_held_ext  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_push & w_full & ~w_pop) r_ovf <= 1'b1;
      if (w_push & ~w_ev.brk) begin
        r_held_code <= w_ev.code;
        r_held_ext  <= w_ev.ext;
      end else if (w_push & w_ev.brk & w_match) begin
        r_held_code <= 8'h00;
        r_held_ext  <= 1'b0;
      end
    end
  end

  ps2_event_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (clk),
    .i_rst_n (res),
    .i_push  (w_push),
    .i_data  (w_ev),
    .i_pop   (ev_ready),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign ev_valid  = ~w_empty;
  assign ev_code   = w_head.code;
  assign ev_ext    = w_head.ext;
  assign ev_break  = w_head.brk;
  assign overflow  = r_ovf;
  assign held_code = r_held_code;
  assign held_ext  = r_held_ext;

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Sits directly downstream of the PS/2 serial receiver. Consumes its stream of 8-bit scan-code bytes and turns prefix sequences (E0 extended, F0 break) into complete key events. Each event carries a make/break flag. Typematic auto-repeat is filtered out, and the events are buffered in a small FIFO behind a valid/ready handshake for the display/control logic.

## Interface
- DEPTH, 4, event FIFO depth; power of two, ≥ 2
- TIMEOUT, 50000, clk cycles a partial prefix sequence may idle before being abandoned
- clk  input  1  system clock, rising edge
- res  input  1  reset, asynchronous, active-low
- code_in  input  8  scan-code byte from receiver
- code_valid  input  1  one-cycle strobe, code_in valid; synchronous to clk (upstream synchronizes)
- ev_code  output  8  head-of-FIFO key code
- ev_ext  output  1  head event had E0 prefix
- ev_break  output  1  head event is a release
- ev_valid  output  1  FIFO non-empty
- ev_ready  input  1  consumer accepts head this cycle
- overflow  output  1  sticky: an event was dropped on full FIFO
- held_code  output  8  code of currently held key, 8'h00 when none
- held_ext  output  1  ext flag of held key

## Operation
- FSM states: IDLE, EXT, BRK, EXT_BRK; evaluated only on cycles with code_valid (except timeout).
- IDLE:
  - E0 → EXT
  - F0 → BRK
  - 00, FF, AA, FA, FE → discard, stay
  - any other byte → make event, ext=0
- EXT:
  - F0 → EXT_BRK
  - E0 → stay
  - 00/FF/AA/FA/FE → discard, stay
  - other byte → make event, ext=1, → IDLE
- BRK / EXT_BRK:
  - E0 and F0 → discard, stay
  - 00/FF/AA/FA/FE → discard, stay
  - other byte → break event, ext=0 (BRK) or ext=1 (EXT_BRK), → IDLE
- Typematic filter:
  - Make event whose {ext,code} equals {held_ext,held_code} with held_code≠0 is dropped.
  - Other make events are pushed and update held.
- Break events are always pushed. If {ext,code} matches held, held clears to {0,00}.
- Timeout:
  - Counter clears on every code_valid.
  - In non-IDLE state, reaching TIMEOUT-1 cycles without code_valid forces IDLE.
  - No event is produced on timeout.
- FIFO:
  - Show-ahead; pop when ev_valid & ev_ready.
  - Push when full and no pop in the same cycle: event dropped, overflow set; overflow stays set until reset.
  - Push and pop in the same cycle while full: both proceed, no overflow.
  - Push and pop in the same cycle while empty: the new event appears next cycle.
- Pointers wrap modulo DEPTH. Occupancy count is clog2(DEPTH)+1 bits.

## Timing
- Reset (res=0) is asynchronous. All of the following take effect immediately:
  - FSM → IDLE
  - FIFO empty, ev_valid=0
  - ev_code=00, ev_ext=0, ev_break=0
  - overflow=0
  - held_code=00, held_ext=0
  - timeout counter=0
- Reset mid-sequence abandons the prefix silently.
- Latency: code_valid at edge N → FSM/held updated at N+1. If the FIFO was empty, ev_valid=1 with the new event at N+1.
- Back-to-back code_valid on consecutive cycles must be handled; throughput is 1 byte/cycle.
- Head outputs are stable while ev_valid=1 and ev_ready=0.
- Outputs are registered (FIFO storage). ev_valid is derived from registered occupancy.

## Structure
- Package ps2_pkg holds:
  - constants PS2_EXT=8'hE0, PS2_BRK=8'hF0
  - discard codes 00, FF, AA, FA, FE
  - enum dec_state_t {IDLE, EXT, BRK, EXT_BRK}
  - packed struct key_event_t {ext, brk, code[7:0]}, 10 bits
- Sub-module ps2_event_fifo: parametric synchronous show-ahead FIFO of key_event_t, with full/empty flags, active-low async reset.
- Top file holds the FSM, typematic filter, timeout counter and overflow flag.

## Test plan
- Bytes 1C; F0 1C, ready=1 → events {1C,ext0,brk0} then {1C,0,1}; held_code 1C after first, 00 after second.
- Bytes E0 75; E0 F0 75 → {75,1,0}, {75,1,1}; held_ext=1 then held {0,00}. Byte AA interleaved in IDLE → no event.
- Bytes 1C 1C 1C 1C (typematic) → exactly one make event. Then 32 → make 32, held=32.
- ev_ready=0, makes 15 1D 24 2D 2C (DEPTH=4) → ev_valid=1, overflow=1 after fifth byte. Release ready → 15 1D 24 2D drained in order, ev_valid drops after fourth pop.
- Byte F0, then TIMEOUT idle cycles, then 1C → make {1C,0,0} (not break). Same with TIMEOUT-2 idle cycles → break {1C,0,1}.
- FIFO holding 2 events, FSM in EXT, overflow=1, assert res=0 mid-cycle → all outputs zero before next edge. Release, byte 75 → make {75,ext0,0}.
